// File: rtl/regfile_wb_pkg.sv
// Shared constants, entry type and pointer helper for the register-file writeback queue.
package regfile_wb_pkg;

    localparam int REG_W    = 32;
    localparam int SEL_W    = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] data;
    } wb_entry_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1) % depth;
    endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Push channel from execute/memory stages and the register-file write port of the queue.
interface regfile_wb_queue_if #(
    parameter int SEL_W  = 5,
    parameter int DATA_W = 32
);
    // Push handshake: an entry transfers at a posedge where in_valid && in_ready.
    // in_ready depends only on registered occupancy; the write port never back-pressures.
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] in_data;
    logic              en;
    logic [SEL_W-1:0]  write_sel;
    logic [DATA_W-1:0] write_data;

    modport master (
        output in_valid, in_sel, in_data,
        input  in_ready, en, write_sel, write_data
    );

    modport slave (
        input  in_valid, in_sel, in_data,
        output in_ready, en, write_sel, write_data
    );
endinterface

// File: rtl/wb_lookup.sv
// Combinational pending-write lookup: youngest valid entry matching q_sel wins.
module wb_lookup
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SEL_W  = 5,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][SEL_W-1:0]  sel_mem,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_mem,
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [CNT_W-1:0]             count,
    input  logic [SEL_W-1:0]             q_sel,
    output logic                         q_hit,
    output logic [DATA_W-1:0]            q_data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        idx    = rd_ptr;
        for (int a = 0; a < DEPTH; a++) begin
            if ((CNT_W'(a) < count) && (sel_mem[idx] == q_sel)) begin
                q_hit  = 1'b1;
                q_data = data_mem[idx];
            end
            idx = PTR_W'(ptr_inc(32'(idx), DEPTH));
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the register-file write port, with two bypass lookups.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_queue_if.slave    wb,
    input  logic                 hold,
    input  logic [SEL_W-1:0]     q1_sel,
    input  logic [SEL_W-1:0]     q2_sel,
    output logic                 q1_hit,
    output logic                 q2_hit,
    output logic [DATA_W-1:0]    q1_data,
    output logic [DATA_W-1:0]    q2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import regfile_wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0][SEL_W-1:0]  sel_mem_q, sel_mem_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem_q, data_mem_d;
    logic                         not_empty, not_full, push, pop;

    always_comb begin
        not_empty  = (count_q != '0);
        not_full   = (count_q != CNT_W'(DEPTH));
        push       = wb.in_valid && not_full;
        pop        = not_empty && !hold;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sel_mem_d  = sel_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            sel_mem_d[wr_ptr_q]  = wb.in_sel;
            data_mem_d[wr_ptr_q] = wb.in_data;
            wr_ptr_d             = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sel_mem_q  <= '0;
            data_mem_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sel_mem_q  <= sel_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    // The head is shown even under hold so the port is never stale; en alone gates the write.
    assign wb.in_ready   = not_full;
    assign wb.en         = pop;
    assign wb.write_sel  = not_empty ? sel_mem_q[rd_ptr_q]  : '0;
    assign wb.write_data = not_empty ? data_mem_q[rd_ptr_q] : '0;
    assign count         = count_q;

    wb_lookup #(.DEPTH(DEPTH), .SEL_W(SEL_W), .DATA_W(DATA_W)) u_lookup_q1 (
        .sel_mem  (sel_mem_q),
        .data_mem (data_mem_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .q_sel    (q1_sel),
        .q_hit    (q1_hit),
        .q_data   (q1_data)
    );

    wb_lookup #(.DEPTH(DEPTH), .SEL_W(SEL_W), .DATA_W(DATA_W)) u_lookup_q2 (
        .sel_mem  (sel_mem_q),
        .data_mem (data_mem_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .q_sel    (q2_sel),
        .q_hit    (q2_hit),
        .q_data   (q2_data)
    );

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback queue that drives the 32 × 32-bit register file's write port (`en`, `write_sel`, `write_data`). Execute and memory stages push results through a valid/ready handshake. The queue buffers them in order and issues at most one register-file write per cycle. It also gives the decode stage a combinational lookup, so it can detect and bypass writes that are still pending.

## Interface
Parameters:
- `DEPTH`, 4, number of queue entries; power of two, ≥ 2.
- `DATA_W`, 32, result and register width.
- `SEL_W`, 5, register index width.

Ports:
- `clk`, input, 1: single clock. Queue state updates on the posedge; the register file samples the write port on the negedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: producer offers a result.
- `in_ready`, output, 1: queue accepts; equals `!full`.
- `in_sel`, input, `SEL_W`: destination register.
- `in_data`, input, `DATA_W`: result value.
- `hold`, input, 1: suppresses issue for the current cycle (debug/stall).
- `en`, output, 1: register-file write enable.
- `write_sel`, output, `SEL_W`: register-file write index.
- `write_data`, output, `DATA_W`: register-file write data.
- `q1_sel`, `q2_sel`, input, `SEL_W`: decode-stage lookup indices.
- `q1_hit`, `q2_hit`, output, 1: a pending entry targets the queried register.
- `q1_data`, `q2_data`, output, `DATA_W`: data of the youngest matching entry; 0 when there is no hit.
- `count`, output, `$clog2(DEPTH+1)`: current occupancy.

## Operation
- Storage is a circular buffer with `wr_ptr`, `rd_ptr` (`$clog2(DEPTH)` bits each, wrapping modulo `DEPTH`) and an occupancy counter.
- Push: `in_valid && in_ready` at a posedge. The entry is written at `wr_ptr` and `wr_ptr` increments.
- Issue: `en = (count != 0) && !hold`. `write_sel`/`write_data` show the head entry when `count != 0`, and are 0 otherwise.
- Pop: at a posedge where `en` was 1, `rd_ptr` increments. The register file always accepts, so there is no back-pressure on issue.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full: `in_ready = 0`. A push is not accepted in a cycle where a pop frees a slot. `in_ready` depends only on the registered `count`, with no combinational path from `hold`.
- Empty: `en = 0`. A result pushed into an empty queue is never passed straight through to the write port.
- Register 0 has no special handling; it is written like any other index.
- Lookup:
  - Scan all valid entries, including the head even when it is issuing this cycle.
  - The hit with the highest age (closest to `wr_ptr`) wins.
  - The lookup is purely combinational on the stored state.
  - The incoming `in_*` entry is not included.
- Ordering: writes issue in strict push order. Multiple entries may target the same index; every one of them issues.
- `hold` only freezes issue; pushes continue until the queue is full.
- Reset (asynchronous, at any time, including mid-drain): pointers and count clear to 0 and pending entries are discarded.
  - Outputs during and after reset: `en=0`, `write_sel=0`, `write_data=0`, `q*_hit=0`, `q*_data=0`, `count=0`, `in_ready=1`.

## Timing
- A push accepted at posedge N drives `en=1` with its data in cycle N+1 (if it is at the head and `hold=0`).
- The register file writes it at the negedge inside cycle N+1, and it is popped at posedge N+1.
- Minimum push-to-regfile-visible latency is 1.5 cycles. Its register-file read value is valid from that negedge on.
- From posedge N until the pop, `q_hit` covers the entry, so decode never sees a stale value.
- Sustained throughput is one write per cycle with no bubble when `hold=0`.

## Structure
- Package `regfile_wb_pkg`:
  - Constants `REG_W=32`, `SEL_W=5`, `NUM_REGS=32`.
  - Struct `wb_entry_t {sel, data}`.
  - Function `ptr_inc`, which wraps modulo `DEPTH`.
- One sub-module, `wb_lookup`: a priority match over the entries, ordered by age relative to `rd_ptr`. It is instantiated twice, once per query port.
- The queue control lives in the top level.

## Test plan
- **Reset and single push.** After reset, check `in_ready=1`, `en=0`, `count=0`. Push `(sel=3, data=0xDEADBEEF)`. In the next cycle expect `en=1, write_sel=3`. After the negedge the register file reads 0xDEADBEEF, and `count` returns to 0.
- **Fill under hold.** With `hold=1`, push 4 entries. Expect `count=4` and `in_ready=0`. A fifth `in_valid` is not accepted. Release `hold`: writes issue on 4 consecutive cycles in push order.
- **Same-index bypass.** Push `(5,0x11)` then `(5,0x22)` with `hold=1`. Expect `q1_sel=5` to give `hit=1, data=0x22`, and `q2_sel=6` to give `hit=0, data=0`. After the first pop, the lookup still returns 0x22. After the second pop, `hit=0`.
- **Wrap-around.** Run a continuous stream of 10 pushes with `hold=0`. Expect exactly 10 writes, in order, with one write per cycle and `count` never above 1.
- **Simultaneous push and pop at full.** Fill the queue, then release `hold` while holding `in_valid=1`. Expect `in_ready=0` in the pop cycle. The push is accepted the following cycle.
- **Reset mid-drain.** Assert `rst_n=0` between clock edges while 3 entries are pending. Expect `en`, `count` and the hits to clear immediately. No further writes occur after reset releases.
